hpm_event_unit: RTL

Event-selection front end for the hardware performance monitor. Holds one event selector per programmable counter plus the counter-inhibit mask, and watches the core's per-cycle event pulses. Each cycle it produces a registered increment strobe per counter, filtered by privilege mode and debug freeze. Its `inc_en` vector drives the enable inputs of the hpm counter bank directly downstream. It exposes the same CSR-extension handshake used by the other privileged extensions.

---
 rtl/hpm_event_unit_if.sv | 35 +++
 rtl/hpm_event_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hpm_event_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hpm_event_unit_if
// Description : CSR-extension handshake bundle shared by the privileged
//               extensions. The priv unit acts as master and presents an
//               address, an active flag and merged write data. The extension
//               acts as slave and answers with read data, an ownership ack
//               and an invalid flag, all within the same cycle.
//   csr_addr    [11:0] : CSR address of the current access
//   csr_active         : access in progress this cycle
//   value_in    [31:0] : write data, already merged by the priv unit
//   value_out   [31:0] : read data (pre-write value)
//   ack                : address owned by the extension
//   invalid_csr        : active access to an address nobody here owns
// Revision    : 1.0 - initial release
// ============================================================================
interface hpm_event_unit_if;
    logic [11:0] csr_addr;
    logic        csr_active;
    logic [31:0] value_in;
    logic [31:0] value_out;
    logic        ack;
    logic        invalid_csr;

    modport master (
        output csr_addr, csr_active, value_in,
        input  value_out, ack, invalid_csr
    );

    modport slave (
        input  csr_addr, csr_active, value_in,
        output value_out, ack, invalid_csr
    );
endinterface
`default_nettype wire

// File: rtl/hpm_event_unit.sv
`default_nettype none
// ============================================================================
// Module      : hpm_event_unit
// Description : Event-selection front end for the hardware performance
//               monitor. Holds one mhpmevent selector per programmable
//               counter plus mcountinhibit, and turns the core's per-cycle
//               event pulses into a registered increment strobe per counter,
//               filtered by privilege mode, per-counter inhibit and debug
//               freeze.
//   clk                      : clock
//   n_rst                    : asynchronous active-low reset
//   csr                      : CSR-extension handshake (slave side)
//   priv_mode   [1:0]        : current privilege, 2'b11 = M, 2'b00 = U
//   debug_freeze             : core halted in debug, suppresses all counting
//   event_pulse [NUM_EVENTS] : per-cycle event pulses, bit 0 means no event
//   inc_en      [NUM_COUNTERS]: registered increment strobe per counter
// Registers:
//   0x320        mcountinhibit, bit 3+i inhibits counter i
//   0x323+i      mhpmevent(3+i): [31] MINH, [30] UINH, [7:0] SEL
// Revision    : 1.0 - initial release
// ============================================================================
module hpm_event_unit #(
    parameter int NUM_COUNTERS = 2,
    parameter int NUM_EVENTS   = 8
) (
    input  wire logic                    clk,
    input  wire logic                    n_rst,
    hpm_event_unit_if.slave              csr,
    input  wire logic [1:0]              priv_mode,
    input  wire logic                    debug_freeze,
    input  wire logic [NUM_EVENTS-1:0]   event_pulse,
    output logic      [NUM_COUNTERS-1:0] inc_en
);

    localparam logic [11:0] c_addr_inhibit    = 12'h320;
    localparam logic [11:0] c_addr_event_base = 12'h323;
    localparam logic [1:0]  c_priv_u          = 2'b00;
    localparam logic [1:0]  c_priv_m          = 2'b11;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [NUM_COUNTERS-1:0] r_inhibit;
    logic                    w_sel_inhibit;
    logic [NUM_COUNTERS-1:0] w_sel_event;
    logic                    w_ack;
    logic [31:0]             w_inhibit_word;
    logic [31:0]             w_event_word [NUM_COUNTERS];
    logic [31:0]             w_rdata;
    logic [255:0]            w_events;
    logic [NUM_COUNTERS-1:0] w_inc_next;
    logic                    w_unused;

    // ------------------------------------------------------------------------
    // Address decode and handshake
    // ------------------------------------------------------------------------
    assign w_sel_inhibit   = (csr.csr_addr == c_addr_inhibit);
    assign w_ack           = csr.csr_active & (w_sel_inhibit | (|w_sel_event));
    assign csr.ack         = w_ack;
    assign csr.invalid_csr = csr.csr_active & ~w_ack;

    // mcountinhibit only implements bits 3 .. 3+NUM_COUNTERS-1.
    always_comb begin
        w_inhibit_word = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            w_inhibit_word[3+i] = r_inhibit[i];
        end
    end

    // Addresses are mutually exclusive, so at most one source is selected.
    always_comb begin
        w_rdata = '0;
        if (csr.csr_active) begin
            if (w_sel_inhibit) begin
                w_rdata = w_inhibit_word;
            end
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (w_sel_event[i]) begin
                    w_rdata = w_event_word[i];
                end
            end
        end
    end

    assign csr.value_out = w_rdata;

    // ------------------------------------------------------------------------
    // Event vector widened to the full SEL range. Bit 0 and every index at or
    // above NUM_EVENTS stay zero, so an out-of-range or zero SEL never hits
    // without needing a separate range compare.
    // ------------------------------------------------------------------------
    always_comb begin
        w_events = '0;
        for (int k = 1; k < NUM_EVENTS; k++) begin
            w_events[k] = event_pulse[k];
        end
    end

    // ------------------------------------------------------------------------
    // mcountinhibit
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_inhibit <= '0;
        end else if (w_ack && w_sel_inhibit) begin
            r_inhibit <= csr.value_in[3 +: NUM_COUNTERS];
        end
    end

    // ------------------------------------------------------------------------
    // Per-counter selector and strobe qualification
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_counter
        localparam logic [11:0] c_addr = c_addr_event_base + 12'(g);

        logic [7:0] r_sel;
        logic       r_uinh;
        logic       r_minh;
        logic       w_hit;
        logic       w_blocked;

        assign w_sel_event[g] = (csr.csr_addr == c_addr);

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_sel  <= '0;
                r_uinh <= 1'b0;
                r_minh <= 1'b0;
            end else if (w_ack && w_sel_event[g]) begin
                r_sel  <= csr.value_in[7:0];
                r_uinh <= csr.value_in[30];
                r_minh <= csr.value_in[31];
            end
        end

        assign w_event_word[g] = {r_minh, r_uinh, 22'd0, r_sel};

        // Supervisor/hypervisor encodings are never filtered by MINH/UINH.
        assign w_hit     = w_events[r_sel];
        assign w_blocked = r_inhibit[g] | debug_freeze
                         | ((priv_mode == c_priv_m) & r_minh)
                         | ((priv_mode == c_priv_u) & r_uinh);

        // Uses the registered selector, so a CSR write in the same cycle only
        // affects strobes computed from the following cycle onward.
        assign w_inc_next[g] = w_hit & ~w_blocked;
    end

    // ------------------------------------------------------------------------
    // Strobe register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            inc_en <= '0;
        end else begin
            inc_en <= w_inc_next;
        end
    end

    // Write-data bits without a backing flop, and the reserved event bit 0.
    assign w_unused = ^{csr.value_in, event_pulse[0]};

endmodule
`default_nettype wire
